// File: rtl/dma_rect_engine.sv
// 2D rectangle fill/copy DMA between the CPU register bus and the SDRAM word port.
// Define DMA_COLORKEY_EN to enable colour-key skipping of copied words.
module dma_rect_engine #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned BURST  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              reg_wr,
  input  logic [3:0]        reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata,
  output logic              sdram_rd,
  output logic              sdram_wr,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [31:0]       sdram_wdata,
  output logic [3:0]        sdram_wstrb,
  input  logic [31:0]       sdram_rdata,
  input  logic              sdram_busy,
  input  logic              sdram_rdata_valid,
  output logic              active,
  output logic              done_pulse
);
  localparam int unsigned IdxW = $clog2(BURST) + 1;
  localparam int unsigned BufW = $clog2(BURST);

  typedef enum logic [2:0] {
    StIdle, StFillIssue, StFillWait, StRdIssue, StRdWait, StWrIssue, StWrWait, StRowAdv
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       src_addr_q, src_addr_d, dst_addr_q, dst_addr_d;
  logic [CNT_W-1:0]  width_q, width_d, height_q, height_d;
  logic [31:0]       src_stride_q, src_stride_d, dst_stride_q, dst_stride_d;
  logic [31:0]       fill_q, fill_d;
  logic              mode_q, mode_d, abort_q, abort_d;
  logic              done_q, done_d, aborted_q, aborted_d;
  logic              done_pulse_q, done_pulse_d, seen_busy_q, seen_busy_d;
  logic [31:0]       src_row_q, src_row_d, dst_row_q, dst_row_d;
  logic [CNT_W-1:0]  col_q, col_d, row_q, row_d;
  logic [IdxW-1:0]   idx_q, idx_d, chunk_q, chunk_d;
  logic [31:0]       buf_q [BURST];
  logic [31:0]       buf_d [BURST];
`ifdef DMA_COLORKEY_EN
  logic [31:0]       colorkey_q, colorkey_d;
  logic              key_en_q, key_en_d;
`endif

  logic              start, abort_wr, wr_step, abort_exit;
  logic [31:0]       col_off, cmd_addr;
  logic [CNT_W-1:0]  col_inc, col_next;
  logic [BufW-1:0]   bidx;
  logic              unused_cmd_addr;

  function automatic logic [IdxW-1:0] chunk_of(input logic [CNT_W-1:0] rem);
    if (rem >= CNT_W'(BURST)) return IdxW'(BURST);
    return rem[IdxW-1:0];
  endfunction

  assign active          = (state_q != StIdle);
  assign done_pulse      = done_pulse_q;
  assign start           = reg_wr && (reg_addr == 4'd7) && reg_wdata[0] && !active;
  assign abort_wr        = reg_wr && (reg_addr == 4'd7) && reg_wdata[2] && active;
  assign col_off         = 32'(col_q) + 32'(idx_q);
  assign col_inc         = col_q + CNT_W'(1);
  assign col_next        = col_q + CNT_W'(chunk_q);
  assign bidx            = idx_q[BufW-1:0];
  assign sdram_addr      = cmd_addr[ADDR_W+1:2];
  assign unused_cmd_addr = ^{cmd_addr[1:0], cmd_addr[31:ADDR_W+2]};

  always_comb begin
    state_d      = state_q;
    src_addr_d   = src_addr_q;
    dst_addr_d   = dst_addr_q;
    width_d      = width_q;
    height_d     = height_q;
    src_stride_d = src_stride_q;
    dst_stride_d = dst_stride_q;
    fill_d       = fill_q;
    mode_d       = mode_q;
    abort_d      = abort_q | abort_wr;
    done_d       = done_q;
    aborted_d    = aborted_q;
    done_pulse_d = 1'b0;
    seen_busy_d  = seen_busy_q;
    src_row_d    = src_row_q;
    dst_row_d    = dst_row_q;
    col_d        = col_q;
    row_d        = row_q;
    idx_d        = idx_q;
    chunk_d      = chunk_q;
    buf_d        = buf_q;
`ifdef DMA_COLORKEY_EN
    colorkey_d   = colorkey_q;
    key_en_d     = key_en_q;
`endif
    wr_step      = 1'b0;
    abort_exit   = 1'b0;
    sdram_rd     = 1'b0;
    sdram_wr     = 1'b0;
    cmd_addr     = 32'h0;
    sdram_wdata  = 32'h0;
    sdram_wstrb  = 4'h0;

    if (reg_wr && !active) begin
      case (reg_addr)
        4'd0: src_addr_d   = reg_wdata;
        4'd1: dst_addr_d   = reg_wdata;
        4'd2: width_d      = reg_wdata[CNT_W-1:0];
        4'd3: height_d     = reg_wdata[CNT_W-1:0];
        4'd4: src_stride_d = reg_wdata;
        4'd5: dst_stride_d = reg_wdata;
        4'd6: fill_d       = reg_wdata;
`ifdef DMA_COLORKEY_EN
        4'd9: colorkey_d   = reg_wdata;
`endif
        default: ;
      endcase
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          done_d    = 1'b0;
          aborted_d = 1'b0;
          abort_d   = 1'b0;
          mode_d    = reg_wdata[1];
`ifdef DMA_COLORKEY_EN
          key_en_d  = reg_wdata[3];
`endif
          src_row_d = src_addr_q;
          dst_row_d = dst_addr_q;
          col_d     = '0;
          row_d     = '0;
          idx_d     = '0;
          if (width_q == '0 || height_q == '0) begin
            done_d       = 1'b1;
            done_pulse_d = 1'b1;
          end else if (reg_wdata[1]) begin
            state_d = StRdIssue;
            chunk_d = chunk_of(width_q);
          end else begin
            state_d = StFillIssue;
          end
        end
      end
      StFillIssue: begin
        if (abort_q) begin
          abort_exit = 1'b1;
        end else if (!sdram_busy) begin
          sdram_wr    = 1'b1;
          cmd_addr    = dst_row_q + (col_off << 2);
          sdram_wdata = fill_q;
          sdram_wstrb = 4'hF;
          seen_busy_d = 1'b0;
          state_d     = StFillWait;
        end
      end
      StFillWait: begin
        if (sdram_busy) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy_q) begin
          col_d = col_inc;
          if (abort_q)                abort_exit = 1'b1;
          else if (col_inc == width_q) state_d = StRowAdv;
          else                        state_d = StFillIssue;
        end
      end
      StRdIssue: begin
        if (abort_q) begin
          abort_exit = 1'b1;
        end else if (!sdram_busy) begin
          sdram_rd = 1'b1;
          cmd_addr = src_row_q + (col_off << 2);
          state_d  = StRdWait;
        end
      end
      StRdWait: begin
        if (sdram_rdata_valid) begin
          buf_d[bidx] = sdram_rdata;
          if (abort_q) begin
            abort_exit = 1'b1;
          end else if (idx_q + IdxW'(1) == chunk_q) begin
            idx_d   = '0;
            state_d = StWrIssue;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StRdIssue;
          end
        end
      end
      StWrIssue: begin
        if (abort_q) begin
          abort_exit = 1'b1;
        end else begin
`ifdef DMA_COLORKEY_EN
          // Keyed words are skipped outright but still consume their column.
          if (key_en_q && (buf_q[bidx] == colorkey_q)) wr_step = 1'b1;
          else
`endif
          if (!sdram_busy) begin
            sdram_wr    = 1'b1;
            cmd_addr    = dst_row_q + (col_off << 2);
            sdram_wdata = buf_q[bidx];
            sdram_wstrb = 4'hF;
            seen_busy_d = 1'b0;
            state_d     = StWrWait;
          end
        end
      end
      StWrWait: begin
        if (sdram_busy)       seen_busy_d = 1'b1;
        else if (seen_busy_q) wr_step     = 1'b1;
      end
      StRowAdv: begin
        if (abort_q) begin
          abort_exit = 1'b1;
        end else begin
          src_row_d = src_row_q + src_stride_q;
          dst_row_d = dst_row_q + dst_stride_q;
          col_d     = '0;
          row_d     = row_q + CNT_W'(1);
          if (row_q + CNT_W'(1) == height_q) begin
            state_d      = StIdle;
            done_d       = 1'b1;
            done_pulse_d = 1'b1;
          end else if (mode_q) begin
            state_d = StRdIssue;
            chunk_d = chunk_of(width_q);
          end else begin
            state_d = StFillIssue;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (wr_step) begin
      if (abort_q) begin
        abort_exit = 1'b1;
      end else if (idx_q + IdxW'(1) == chunk_q) begin
        idx_d = '0;
        col_d = col_next;
        if (col_next == width_q) begin
          state_d = StRowAdv;
        end else begin
          state_d = StRdIssue;
          chunk_d = chunk_of(width_q - col_next);
        end
      end else begin
        idx_d   = idx_q + IdxW'(1);
        state_d = StWrIssue;
      end
    end

    if (abort_exit) begin
      state_d   = StIdle;
      aborted_d = 1'b1;
      abort_d   = 1'b0;
    end
  end

  always_comb begin
    reg_rdata = 32'h0;
    case (reg_addr)
      4'd0: reg_rdata = src_addr_q;
      4'd1: reg_rdata = dst_addr_q;
      4'd2: reg_rdata = 32'(width_q);
      4'd3: reg_rdata = 32'(height_q);
      4'd4: reg_rdata = src_stride_q;
      4'd5: reg_rdata = dst_stride_q;
      4'd6: reg_rdata = fill_q;
      4'd8: reg_rdata = {29'h0, aborted_q, done_q, active};
`ifdef DMA_COLORKEY_EN
      4'd9: reg_rdata = colorkey_q;
`endif
      default: reg_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      src_addr_q   <= '0;
      dst_addr_q   <= '0;
      width_q      <= '0;
      height_q     <= '0;
      src_stride_q <= '0;
      dst_stride_q <= '0;
      fill_q       <= '0;
      mode_q       <= 1'b0;
      abort_q      <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      done_pulse_q <= 1'b0;
      seen_busy_q  <= 1'b0;
      src_row_q    <= '0;
      dst_row_q    <= '0;
      col_q        <= '0;
      row_q        <= '0;
      idx_q        <= '0;
      chunk_q      <= '0;
      for (int i = 0; i < BURST; i++) buf_q[i] <= '0;
`ifdef DMA_COLORKEY_EN
      colorkey_q   <= '0;
      key_en_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      src_addr_q   <= src_addr_d;
      dst_addr_q   <= dst_addr_d;
      width_q      <= width_d;
      height_q     <= height_d;
      src_stride_q <= src_stride_d;
      dst_stride_q <= dst_stride_d;
      fill_q       <= fill_d;
      mode_q       <= mode_d;
      abort_q      <= abort_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      done_pulse_q <= done_pulse_d;
      seen_busy_q  <= seen_busy_d;
      src_row_q    <= src_row_d;
      dst_row_q    <= dst_row_d;
      col_q        <= col_d;
      row_q        <= row_d;
      idx_q        <= idx_d;
      chunk_q      <= chunk_d;
      buf_q        <= buf_d;
`ifdef DMA_COLORKEY_EN
      colorkey_q   <= colorkey_d;
      key_en_q     <= key_en_d;
`endif
    end
  end

endmodule

// File: tb/tb_dma_rect_engine.sv
// Self-checking bench for dma_rect_engine: register table plus fill/copy/stall/abort/reset
// sequences against a small behavioural SDRAM responder.
`timescale 1ns/1ps
module tb_dma_rect_engine;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BURST  = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              reg_wr = 1'b0;
  logic [3:0]        reg_addr = 4'h0;
  logic [31:0]       reg_wdata = 32'h0;
  logic [31:0]       reg_rdata;
  logic              sdram_rd, sdram_wr;
  logic [ADDR_W-1:0] sdram_addr;
  logic [31:0]       sdram_wdata;
  logic [3:0]        sdram_wstrb;
  logic [31:0]       sdram_rdata = 32'h0;
  logic              sdram_busy = 1'b0;
  logic              sdram_rdata_valid = 1'b0;
  logic              active, done_pulse;

  always #5 clk = ~clk;

  dma_rect_engine #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .BURST(BURST)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .reg_wr           (reg_wr),
    .reg_addr         (reg_addr),
    .reg_wdata        (reg_wdata),
    .reg_rdata        (reg_rdata),
    .sdram_rd         (sdram_rd),
    .sdram_wr         (sdram_wr),
    .sdram_addr       (sdram_addr),
    .sdram_wdata      (sdram_wdata),
    .sdram_wstrb      (sdram_wstrb),
    .sdram_rdata      (sdram_rdata),
    .sdram_busy       (sdram_busy),
    .sdram_rdata_valid(sdram_rdata_valid),
    .active           (active),
    .done_pulse       (done_pulse)
  );

  // Unwritten locations return a fixed pattern; 0x1800..0x1803 hold the colour-key row.
  function automatic logic [31:0] src_word(input logic [ADDR_W-1:0] a);
    case (a)
      24'h001800: return 32'h1;
      24'h001801: return 32'hFF;
      24'h001802: return 32'h2;
      24'h001803: return 32'hFF;
      default:    return 32'hA500_0000 | 32'(a);
    endcase
  endfunction

  logic [31:0]       mem [logic [ADDR_W-1:0]];
  logic [ADDR_W-1:0] wa_q [$];
  logic [31:0]       wd_q [$];
  bit                kind_q [$];
  logic [ADDR_W-1:0] rd_pend = '0;
  int wr_count = 0, rd_count = 0, busy_viol = 0, strb_viol = 0, pulse_count = 0, cyc = 0;
  int last_busy_cyc = 0, last_pulse_cyc = 0;
  int busy_cnt = 0, rd_cnt = 0, pre_cnt = 0, stall_ack = 0;
  int stall_tok = 0;
  bit stall_mode = 1'b0;

  // Inputs change on the falling edge; commands are sampled once the DUT has settled.
  always @(negedge clk) begin
    cyc++;
    if (stall_tok != stall_ack) begin
      pre_cnt   = 5;
      stall_ack = stall_tok;
    end
    sdram_rdata_valid = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        sdram_rdata_valid = 1'b1;
        sdram_rdata = mem.exists(rd_pend) ? mem[rd_pend] : src_word(rd_pend);
      end
    end
    sdram_busy = (busy_cnt > 0) || (pre_cnt > 0);
    if (sdram_busy) last_busy_cyc = cyc;
    if (busy_cnt > 0) busy_cnt--;
    if (pre_cnt > 0) pre_cnt--;
    #1;
    if (done_pulse) begin
      pulse_count++;
      last_pulse_cyc = cyc;
    end
    if ((sdram_wr || sdram_rd) && sdram_busy) busy_viol++;
    if (sdram_wr) begin
      if (sdram_wstrb != 4'hF) strb_viol++;
      mem[sdram_addr] = sdram_wdata;
      wa_q.push_back(sdram_addr);
      wd_q.push_back(sdram_wdata);
      kind_q.push_back(1'b1);
      wr_count++;
      busy_cnt = stall_mode ? 7 : 2;
    end
    if (sdram_rd) begin
      rd_pend = sdram_addr;
      rd_cnt  = 2;
      kind_q.push_back(1'b0);
      rd_count++;
    end
  end

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_wr    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    @(negedge clk);
    reg_wr    = 1'b0;
  endtask

  task automatic reg_read(input logic [3:0] a, output logic [31:0] d);
    reg_addr = a;
    #1;
    d = reg_rdata;
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (!active) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'h1);
  endtask

  task automatic prog(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] w,
                      input logic [31:0] h, input logic [31:0] ss, input logic [31:0] ds,
                      input logic [31:0] fill);
    reg_write(4'd0, src);
    reg_write(4'd1, dst);
    reg_write(4'd2, w);
    reg_write(4'd3, h);
    reg_write(4'd4, ss);
    reg_write(4'd5, ds);
    reg_write(4'd6, fill);
  endtask

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [11];
    logic [31:0] d;
    int          w0, r0, p0, nw, nk, errs;
    bit          found;
    bit          exp_k [$];

    vecs[0]  = '{4'd0,  32'h1234_5678, 32'h1234_5678};
    vecs[1]  = '{4'd1,  32'h9ABC_DEF0, 32'h9ABC_DEF0};
    vecs[2]  = '{4'd2,  32'h0001_2345, 32'h0000_2345};
    vecs[3]  = '{4'd3,  32'hFFFF_0007, 32'h0000_0007};
    vecs[4]  = '{4'd4,  32'h0000_0100, 32'h0000_0100};
    vecs[5]  = '{4'd5,  32'h8000_0004, 32'h8000_0004};
    vecs[6]  = '{4'd6,  32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[7]  = '{4'd7,  32'h0000_0004, 32'h0000_0000};
    vecs[8]  = '{4'd8,  32'hFFFF_FFFF, 32'h0000_0000};
`ifdef DMA_COLORKEY_EN
    vecs[9]  = '{4'd9,  32'h0000_55AA, 32'h0000_55AA};
`else
    vecs[9]  = '{4'd9,  32'h0000_55AA, 32'h0000_0000};
`endif
    vecs[10] = '{4'd12, 32'hFFFF_FFFF, 32'h0000_0000};

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check("rst_active", 32'(active), 32'h0);
    check("rst_sdram_wr", 32'(sdram_wr), 32'h0);
    check("rst_sdram_rd", 32'(sdram_rd), 32'h0);
    check("rst_sdram_addr", 32'(sdram_addr), 32'h0);
    check("rst_done_pulse", 32'(done_pulse), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    reg_read(4'd8, d);
    check("rst_status", d, 32'h0);

    // Register map
    for (int i = 0; i < 11; i++) begin
      reg_write(vecs[i].addr, vecs[i].wdata);
      reg_read(vecs[i].addr, d);
      check($sformatf("reg_vec%0d", i), d, vecs[i].exp);
    end
    reg_read(4'd8, d);
    check("reg_no_start", d, 32'h0);

    // Fill 4x3
    w0 = wr_count; r0 = rd_count; p0 = pulse_count; nw = wa_q.size();
    prog(32'h0, 32'h1000, 32'd4, 32'd3, 32'h0, 32'h40, 32'hDEAD_BEEF);
    reg_write(4'd7, 32'h1);
    wait_idle(400, "fill_finish");
    check("fill_wr_count", 32'(wr_count - w0), 32'd12);
    check("fill_rd_count", 32'(rd_count - r0), 32'd0);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("fill_addr_r%0dc%0d", r, c), 32'(wa_q[nw + r * 4 + c]),
              32'h400 + 32'(r * 16 + c));
        check($sformatf("fill_data_r%0dc%0d", r, c), wd_q[nw + r * 4 + c], 32'hDEAD_BEEF);
      end
    end
    reg_read(4'd8, d);
    check("fill_status", d, 32'h2);
    check("fill_pulses", 32'(pulse_count - p0), 32'd1);

    // Copy 10x2 with chunking
    w0 = wr_count; r0 = rd_count; p0 = pulse_count; nw = wa_q.size(); nk = kind_q.size();
    prog(32'h0, 32'h2000, 32'd10, 32'd2, 32'h100, 32'h100, 32'h0);
    reg_write(4'd7, 32'h3);
    wait_idle(1000, "copy_finish");
    check("copy_wr_count", 32'(wr_count - w0), 32'd20);
    check("copy_rd_count", 32'(rd_count - r0), 32'd20);
    for (int r = 0; r < 2; r++) begin
      repeat (8) exp_k.push_back(1'b0);
      repeat (8) exp_k.push_back(1'b1);
      repeat (2) exp_k.push_back(1'b0);
      repeat (2) exp_k.push_back(1'b1);
    end
    errs = 0;
    for (int i = 0; i < exp_k.size(); i++) begin
      if (nk + i >= kind_q.size()) errs++;
      else if (kind_q[nk + i] != exp_k[i]) errs++;
    end
    check("copy_order_errs", 32'(errs), 32'd0);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 10; c++) begin
        check($sformatf("copy_addr_r%0dc%0d", r, c), 32'(wa_q[nw + r * 10 + c]),
              32'h800 + 32'(r * 64 + c));
        check($sformatf("copy_data_r%0dc%0d", r, c), wd_q[nw + r * 10 + c],
              src_word(ADDR_W'(r * 64 + c)));
      end
    end
    check("copy_pulses", 32'(pulse_count - p0), 32'd1);

    // Busy stall fill 2x1
    w0 = wr_count; p0 = pulse_count;
    prog(32'h0, 32'h3000, 32'd2, 32'd1, 32'h0, 32'h0, 32'h5A5A_5A5A);
    stall_mode = 1'b1;
    stall_tok++;
    @(negedge clk);
    reg_write(4'd7, 32'h1);
    wait_idle(400, "stall_finish");
    stall_mode = 1'b0;
    check("stall_wr_count", 32'(wr_count - w0), 32'd2);
    check("stall_busy_viol", 32'(busy_viol), 32'd0);
    check("stall_pulses", 32'(pulse_count - p0), 32'd1);
    check("stall_done_after_busy", 32'(last_pulse_cyc > last_busy_cyc), 32'h1);
    check("wstrb_viol", 32'(strb_viol), 32'd0);

    // Abort during third fill write
    w0 = wr_count; p0 = pulse_count;
    prog(32'h0, 32'h4000, 32'd100, 32'd1, 32'h0, 32'h0, 32'h1111_1111);
    reg_write(4'd7, 32'h1);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #2;
      if (wr_count - w0 == 3) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_third_write_seen", 32'(found), 32'h1);
    reg_write(4'd7, 32'h4);
    wait_idle(100, "abort_finish");
    repeat (20) @(negedge clk);
    #2;
    check("abort_wr_count", 32'(wr_count - w0), 32'd3);
    check("abort_active", 32'(active), 32'h0);
    reg_read(4'd8, d);
    check("abort_status", d, 32'h4);
    check("abort_pulses", 32'(pulse_count - p0), 32'd0);

    // Zero height start
    w0 = wr_count; r0 = rd_count; p0 = pulse_count;
    prog(32'h0, 32'h5000, 32'd4, 32'd0, 32'h0, 32'h0, 32'h0);
    reg_write(4'd7, 32'h1);
    #2;
    check("zero_active", 32'(active), 32'h0);
    reg_read(4'd8, d);
    check("zero_status", d, 32'h2);
    repeat (4) @(negedge clk);
    #2;
    check("zero_pulses", 32'(pulse_count - p0), 32'd1);
    check("zero_cmds", 32'((wr_count - w0) + (rd_count - r0)), 32'd0);

    // Reset in the middle of a read
    r0 = rd_count;
    prog(32'h0, 32'h5000, 32'd4, 32'd2, 32'h10, 32'h10, 32'h0);
    reg_write(4'd7, 32'h3);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #2;
      if (rd_count - r0 == 1) begin
        found = 1'b1;
        break;
      end
    end
    check("rstmid_read_seen", 32'(found), 32'h1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstmid_sdram_rd", 32'(sdram_rd), 32'h0);
    check("rstmid_sdram_wr", 32'(sdram_wr), 32'h0);
    check("rstmid_addr", 32'(sdram_addr), 32'h0);
    check("rstmid_wdata", sdram_wdata, 32'h0);
    check("rstmid_wstrb", 32'(sdram_wstrb), 32'h0);
    check("rstmid_active", 32'(active), 32'h0);
    check("rstmid_done_pulse", 32'(done_pulse), 32'h0);
    for (int i = 0; i < 10; i++) begin
      reg_read(4'(i), d);
      check($sformatf("rstmid_reg%0d", i), d, 32'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    w0 = wr_count;
    repeat (10) @(negedge clk);
    #2;
    reg_read(4'd8, d);
    check("rstmid_status_after", d, 32'h0);
    check("rstmid_no_writes", 32'(wr_count - w0), 32'd0);

    // Colour-key copy of [1, FF, 2, FF]
    w0 = wr_count; r0 = rd_count; nw = wa_q.size();
    prog(32'h6000, 32'h7000, 32'd4, 32'd1, 32'h0, 32'h0, 32'h0);
    reg_write(4'd9, 32'hFF);
    reg_write(4'd7, 32'hB);
    wait_idle(400, "key_finish");
    check("key_rd_count", 32'(rd_count - r0), 32'd4);
    reg_read(4'd8, d);
    check("key_status", d, 32'h2);
`ifdef DMA_COLORKEY_EN
    check("key_wr_count", 32'(wr_count - w0), 32'd2);
    check("key_addr0", 32'(wa_q[nw]), 32'h1C00);
    check("key_data0", wd_q[nw], 32'h1);
    check("key_addr1", 32'(wa_q[nw + 1]), 32'h1C02);
    check("key_data1", wd_q[nw + 1], 32'h2);
`else
    check("key_wr_count", 32'(wr_count - w0), 32'd4);
    check("key_addr1", 32'(wa_q[nw + 1]), 32'h1C01);
    check("key_data1", wd_q[nw + 1], 32'hFF);
    check("key_addr2", 32'(wa_q[nw + 2]), 32'h1C02);
    check("key_data2", wd_q[nw + 2], 32'h2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
